// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: AXI3 master bus between the bridge (master) and the SoC fabric (slave)
interface cpu_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: folds the inst-fetch and data sram-like channels into one AXI3 master port.
// Optional macro AXI_BRIDGE_PERF_EN adds read/write/stall performance counters.
module cpu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_sram_req,
  input  logic [1:0]          inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
`ifdef AXI_BRIDGE_PERF_EN
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  cpu_axi_bridge_if.master    axi
);
  localparam int CW = $clog2(OUTST + 1);
  localparam logic [CW-1:0] MAX = CW'(OUTST);
  logic [CW-1:0] inst_cnt, drd_cnt, wr_cnt;
  logic inst_acc, drd_acc, wr_acc;
  logic inst_done, drd_done, wr_done;
  logic unused_ok;
  // Data reads and writes exclude each other so data_ok stays in order and RAW hazards vanish;
  // gating with resetn keeps every handshake low while reset is asserted.
  assign drd_acc  = resetn & data_sram_req & ~data_sram_wr & ~axi.arvalid & (drd_cnt < MAX) & (wr_cnt == '0);
  assign wr_acc   = resetn & data_sram_req & data_sram_wr & ~axi.awvalid & ~axi.wvalid & (wr_cnt < MAX) & (drd_cnt == '0);
  assign inst_acc = resetn & inst_sram_req & ~axi.arvalid & (inst_cnt < MAX) & ~drd_acc;
  assign inst_done = resetn & axi.rvalid & (axi.rid == 4'd0);
  assign drd_done  = resetn & axi.rvalid & (axi.rid == 4'd1);
  assign wr_done   = resetn & axi.bvalid;
  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = drd_acc | wr_acc;
  assign inst_sram_data_ok = inst_done;
  assign data_sram_data_ok = drd_done | wr_done;
  assign inst_sram_rdata   = axi.rdata;
  assign data_sram_rdata   = axi.rdata;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = 2'd1;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = 1'b1;
  assign axi.awid    = 4'd1;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = 2'd1;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = 4'd1;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = 1'b1;
  assign unused_ok   = ^{axi.rresp, axi.rlast, axi.bid, axi.bresp};
  // In-flight counters: accept and completion in the same cycle cancel out.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      inst_cnt <= '0;
      drd_cnt  <= '0;
      wr_cnt   <= '0;
    end else begin
      inst_cnt <= inst_cnt + CW'(inst_acc) - CW'(inst_done);
      drd_cnt  <= drd_cnt + CW'(drd_acc) - CW'(drd_done);
      wr_cnt   <= wr_cnt + CW'(wr_acc) - CW'(wr_done);
    end
  // Read address register: data wins the shared AR slot; held until arready.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arsize  <= '0;
      axi.arid    <= '0;
    end else if (inst_acc | drd_acc) begin
      axi.arvalid <= 1'b1;
      axi.araddr  <= drd_acc ? data_sram_addr : inst_sram_addr;
      axi.arsize  <= {1'b0, drd_acc ? data_sram_size : inst_sram_size};
      axi.arid    <= {3'b000, drd_acc};
    end else if (axi.arready) begin
      axi.arvalid <= 1'b0;
    end
  // Write address register: awvalid drops on its own ready, independent of the W channel.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awsize  <= '0;
    end else if (wr_acc) begin
      axi.awvalid <= 1'b1;
      axi.awaddr  <= data_sram_addr;
      axi.awsize  <= {1'b0, data_sram_size};
    end else if (axi.awready) begin
      axi.awvalid <= 1'b0;
    end
  // Write data register: single-beat burst, drops on wready.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      axi.wvalid <= 1'b0;
      axi.wdata  <= '0;
      axi.wstrb  <= '0;
    end else if (wr_acc) begin
      axi.wvalid <= 1'b1;
      axi.wdata  <= data_sram_wdata;
      axi.wstrb  <= data_sram_wstrb;
    end else if (axi.wready) begin
      axi.wvalid <= 1'b0;
    end
`ifdef AXI_BRIDGE_PERF_EN
  // Performance counters: completed reads, completed writes, cycles with a refused request.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_rd_cnt    <= perf_rd_cnt + 32'(inst_done | drd_done);
      perf_wr_cnt    <= perf_wr_cnt + 32'(wr_done);
      perf_stall_cnt <= perf_stall_cnt + 32'((inst_sram_req & ~inst_sram_addr_ok) | (data_sram_req & ~data_sram_addr_ok));
    end
`endif
`ifndef SYNTHESIS
  // A response with nothing in flight on its channel means the slave broke protocol.
  always @(posedge clk)
    if (resetn) begin
      assert (!inst_done || inst_cnt != '0) else $error("inst read response with no request in flight");
      assert (!drd_done || drd_cnt != '0) else $error("data read response with no request in flight");
      assert (!wr_done || wr_cnt != '0) else $error("write response with no request in flight");
    end
`endif
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed scenario checks for cpu_axi_bridge
module tb_cpu_axi_bridge;
  localparam int AW = 32, DW = 32, OUTST = 2;
  logic clk = 0, resetn = 0;
  always #5 clk = ~clk;
  logic inst_req, data_req, data_wr;
  logic [1:0] inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW/8-1:0] data_wstrb;
  logic [DW-1:0] data_wdata, inst_rdata, data_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  int n_chk = 0, n_fail = 0;
  cpu_axi_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) axi();
  cpu_axi_bridge #(.ADDR_W(AW), .DATA_W(DW), .OUTST(OUTST)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_req), .inst_sram_size(inst_size), .inst_sram_addr(inst_addr),
    .inst_sram_addr_ok(inst_addr_ok), .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_addr(data_addr), .data_sram_wstrb(data_wstrb), .data_sram_wdata(data_wdata),
    .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
    .axi(axi)
  );

  task test_reset;
    inst_req = 1; data_req = 1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b want 0", axi.arvalid); end
    n_chk++; if (axi.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b want 0", axi.awvalid); end
    n_chk++; if (axi.wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid got %b want 0", axi.wvalid); end
    n_chk++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_inst_addr_ok got %b want 0", inst_addr_ok); end
    n_chk++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_addr_ok got %b want 0", data_addr_ok); end
    n_chk++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_data_ok got %b%b want 00", inst_data_ok, data_data_ok); end
    n_chk++; if (axi.araddr !== 32'h0 || axi.awaddr !== 32'h0 || axi.wdata !== 32'h0) begin n_fail++; $display("FAIL rst_payload got %h %h %h want 0", axi.araddr, axi.awaddr, axi.wdata); end
    n_chk++; if (dut.inst_cnt !== 2'd0 || dut.drd_cnt !== 2'd0 || dut.wr_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_cnt got %0d %0d %0d want 0", dut.inst_cnt, dut.drd_cnt, dut.wr_cnt); end
    n_chk++; if (axi.rready !== 1'b1 || axi.bready !== 1'b1 || axi.arburst !== 2'd1 || axi.wlast !== 1'b1 || axi.wid !== 4'd1) begin n_fail++; $display("FAIL const_ties got %b %b %0d %b %0d", axi.rready, axi.bready, axi.arburst, axi.wlast, axi.wid); end
    @(negedge clk);
    inst_req = 0; data_req = 0; resetn = 1;
  endtask

  task test_inst_read;
    @(negedge clk);
    axi.arready = 1; inst_req = 1; inst_size = 2; inst_addr = 32'h1C000000; #1;
    n_chk++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL ird_addr_ok got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; #1;
    n_chk++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1C000000) begin n_fail++; $display("FAIL ird_ar got %b %h want 1 1c000000", axi.arvalid, axi.araddr); end
    n_chk++; if (axi.arid !== 4'd0 || axi.arsize !== 3'd2) begin n_fail++; $display("FAIL ird_arid_size got %0d %0d want 0 2", axi.arid, axi.arsize); end
    n_chk++; if (dut.inst_cnt !== 2'd1) begin n_fail++; $display("FAIL ird_cnt1 got %0d want 1", dut.inst_cnt); end
    @(negedge clk);
    axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h02800C0C; #1;
    n_chk++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL ird_arvalid_clr got %b want 0", axi.arvalid); end
    n_chk++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800C0C) begin n_fail++; $display("FAIL ird_data got %b %h want 1 02800c0c", inst_data_ok, inst_rdata); end
    n_chk++; if (data_data_ok !== 1'b0) begin n_fail++; $display("FAIL ird_route got %b want 0", data_data_ok); end
    @(negedge clk);
    axi.rvalid = 0; #1;
    n_chk++; if (dut.inst_cnt !== 2'd0 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL ird_cnt0 got %0d %b want 0 0", dut.inst_cnt, inst_data_ok); end
  endtask

  task test_arbitration;
    @(negedge clk);
    axi.arready = 0; inst_req = 1; inst_addr = 32'h1C000100;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000200; #1;
    n_chk++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL arb_win got d%b i%b want d1 i0", data_addr_ok, inst_addr_ok); end
    @(negedge clk);
    data_req = 0; #1;
    n_chk++; if (axi.arid !== 4'd1 || axi.araddr !== 32'h80000200) begin n_fail++; $display("FAIL arb_ar_data got %0d %h want 1 80000200", axi.arid, axi.araddr); end
    n_chk++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL arb_inst_blocked got %b want 0", inst_addr_ok); end
    axi.arready = 1;
    @(negedge clk);
    #1;
    n_chk++; if (axi.arvalid !== 1'b0 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL arb_inst_ok got %b %b want 0 1", axi.arvalid, inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'h11112222; #1;
    n_chk++; if (axi.arid !== 4'd0 || axi.araddr !== 32'h1C000100) begin n_fail++; $display("FAIL arb_ar_inst got %0d %h want 0 1c000100", axi.arid, axi.araddr); end
    n_chk++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h11112222 || inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL arb_rid1 got d%b %h i%b want d1 11112222 i0", data_data_ok, data_rdata, inst_data_ok); end
    @(negedge clk);
    axi.rid = 0; axi.rdata = 32'h33334444; #1;
    n_chk++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h33334444 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL arb_rid0 got i%b %h d%b want i1 33334444 d0", inst_data_ok, inst_rdata, data_data_ok); end
    n_chk++; if (dut.drd_cnt !== 2'd0) begin n_fail++; $display("FAIL arb_drd_cnt got %0d want 0", dut.drd_cnt); end
    @(negedge clk);
    axi.rvalid = 0; #1;
    n_chk++; if (dut.inst_cnt !== 2'd0 || axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL arb_idle got %0d %b want 0 0", dut.inst_cnt, axi.arvalid); end
  endtask

  task test_outstanding;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C001000; #1;
    n_chk++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL out_first got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_addr = 32'h1C001004; #1;
    n_chk++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL out_ar_busy got %b want 0", inst_addr_ok); end
    @(negedge clk);
    #1;
    n_chk++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL out_second got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_addr = 32'h1C001008; #1;
    n_chk++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL out_ar_busy2 got %b want 0", inst_addr_ok); end
    @(negedge clk);
    #1;
    n_chk++; if (inst_addr_ok !== 1'b0 || dut.inst_cnt !== 2'd2) begin n_fail++; $display("FAIL out_full got %b %0d want 0 2", inst_addr_ok, dut.inst_cnt); end
    @(negedge clk);
    axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hA5A5A5A5; #1;
    n_chk++; if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b1) begin n_fail++; $display("FAIL out_resp got %b %b want 0 1", inst_addr_ok, inst_data_ok); end
    @(negedge clk);
    axi.rvalid = 0; #1;
    n_chk++; if (inst_addr_ok !== 1'b1 || dut.inst_cnt !== 2'd1) begin n_fail++; $display("FAIL out_third got %b %0d want 1 1", inst_addr_ok, dut.inst_cnt); end
    @(negedge clk);
    inst_req = 0; #1;
    n_chk++; if (dut.inst_cnt !== 2'd2 || axi.arvalid !== 1'b1 || axi.araddr !== 32'h1C001008) begin n_fail++; $display("FAIL out_third_ar got %0d %b %h want 2 1 1c001008", dut.inst_cnt, axi.arvalid, axi.araddr); end
    @(negedge clk);
    axi.rvalid = 1;
    repeat (2) @(negedge clk);
    axi.rvalid = 0; #1;
    n_chk++; if (dut.inst_cnt !== 2'd0) begin n_fail++; $display("FAIL out_drain got %0d want 0", dut.inst_cnt); end
  endtask

  task test_write;
    @(negedge clk);
    axi.awready = 0; axi.wready = 1;
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010; data_wstrb = 4'h3; data_wdata = 32'hDEADBEEF; #1;
    n_chk++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ok got %b want 1", data_addr_ok); end
    @(negedge clk);
    data_req = 0; data_wr = 0; #1;
    n_chk++; if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_valids got %b %b want 1 1", axi.awvalid, axi.wvalid); end
    n_chk++; if (axi.awaddr !== 32'h80000010 || axi.wdata !== 32'hDEADBEEF || axi.wstrb !== 4'h3 || axi.awsize !== 3'd2) begin n_fail++; $display("FAIL wr_payload got %h %h %h %0d want 80000010 deadbeef 3 2", axi.awaddr, axi.wdata, axi.wstrb, axi.awsize); end
    n_chk++; if (axi.awid !== 4'd1 || dut.wr_cnt !== 2'd1) begin n_fail++; $display("FAIL wr_id_cnt got %0d %0d want 1 1", axi.awid, dut.wr_cnt); end
    @(negedge clk);
    #1;
    n_chk++; if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_w_first got w%b aw%b ok%b want w0 aw1 ok0", axi.wvalid, axi.awvalid, data_data_ok); end
    @(negedge clk);
    axi.awready = 1; #1;
    n_chk++; if (axi.awvalid !== 1'b1) begin n_fail++; $display("FAIL wr_aw_held got %b want 1", axi.awvalid); end
    @(negedge clk);
    axi.awready = 0; #1;
    n_chk++; if (axi.awvalid !== 1'b0 || data_data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_aw_clr got %b %b want 0 0", axi.awvalid, data_data_ok); end
  endtask

  task test_read_after_write;
    @(negedge clk);
    axi.arready = 1; data_req = 1; data_wr = 0; data_addr = 32'h80000020; #1;
    n_chk++; if (data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL raw_blocked got %b want 0", data_addr_ok); end
    @(negedge clk);
    axi.bvalid = 1; #1;
    n_chk++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL raw_bresp got ok%b aok%b want ok1 aok0", data_data_ok, data_addr_ok); end
    @(negedge clk);
    axi.bvalid = 0; #1;
    n_chk++; if (data_addr_ok !== 1'b1 || dut.wr_cnt !== 2'd0) begin n_fail++; $display("FAIL raw_accept got %b %0d want 1 0", data_addr_ok, dut.wr_cnt); end
    @(negedge clk);
    data_req = 0; #1;
    n_chk++; if (axi.arvalid !== 1'b1 || axi.arid !== 4'd1 || axi.araddr !== 32'h80000020) begin n_fail++; $display("FAIL raw_ar got %b %0d %h want 1 1 80000020", axi.arvalid, axi.arid, axi.araddr); end
    @(negedge clk);
    axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'hCAFEF00D; #1;
    n_chk++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL raw_rdata got %b %h want 1 cafef00d", data_data_ok, data_rdata); end
    @(negedge clk);
    axi.rvalid = 0; #1;
    n_chk++; if (dut.drd_cnt !== 2'd0) begin n_fail++; $display("FAIL raw_cnt got %0d want 0", dut.drd_cnt); end
  endtask

  task test_async_reset;
    @(negedge clk);
    axi.arready = 0; inst_req = 1; inst_addr = 32'h1C002000;
    @(negedge clk);
    #1;
    n_chk++; if (axi.arvalid !== 1'b1 || dut.inst_cnt !== 2'd1) begin n_fail++; $display("FAIL ar_pre got %b %0d want 1 1", axi.arvalid, dut.inst_cnt); end
    #1 resetn = 0;
    #1;
    n_chk++; if (axi.arvalid !== 1'b0 || dut.inst_cnt !== 2'd0 || axi.araddr !== 32'h0) begin n_fail++; $display("FAIL ar_async got %b %0d %h want 0 0 0", axi.arvalid, dut.inst_cnt, axi.araddr); end
    n_chk++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL ar_addr_ok got %b want 0", inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; resetn = 1;
    @(negedge clk);
    #1;
    n_chk++; if (axi.arvalid !== 1'b0 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL ar_after got %b %b want 0 0", axi.arvalid, inst_addr_ok); end
  endtask

  initial begin
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = 1; axi.bresp = 0; axi.bvalid = 0;
    test_reset;
    test_inst_read;
    test_arbitration;
    test_outstanding;
    test_write;
    test_read_after_write;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
